// File: rtl/dynamic_ca_rule_extractor.sv
// rtl/dynamic_ca_rule_extractor.sv - learns an elementary CA rule from a stream of generations
// Optional next-generation prediction outputs are built when CA_EXTRACT_PREDICT_EN is defined.
module dynamic_ca_rule_extractor #(
    parameter int Width = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [Width-1:0]         in_state,
    output logic                     in_ready,
    output logic [7:0]               rule,
    output logic [7:0]               known,
    output logic                     done,
    output logic                     conflict,
    output logic [$clog2(Width)-1:0] conflict_cell,
    output logic [15:0]              pairs
`ifdef CA_EXTRACT_PREDICT_EN
    ,
    output logic [Width-1:0]         predict,
    output logic                     predict_valid
`endif
);
    localparam int IW = $clog2(Width);

    typedef enum logic [1:0] {EMPTY, READY, SCAN, HALT} state_t;

    state_t          state;
    logic [Width-1:0] prev;
    logic [Width-1:0] cur;
    logic [IW-1:0]    idx;

    // Right neighbour wraps around; cell 0 borrows itself as its left neighbour.
    function automatic logic [2:0] nbhd(input logic [Width-1:0] g, input int i);
        int right;
        int left;
        right = (i == Width - 1) ? 0 : i + 1;
        left  = (i == 0) ? 0 : i - 1;
        return {g[right], g[i], g[left]};
    endfunction

    logic [2:0] n;
    logic       b;
    logic       mismatch;
    logic       last_cell;

    always_comb begin
        n         = nbhd(prev, int'(idx));
        b         = cur[idx];
        mismatch  = known[n] && (rule[n] != b);
        last_cell = (idx == IW'(Width - 1));
    end

    assign in_ready = ce && !rst && ((state == EMPTY) || (state == READY));
    assign done     = &known;

`ifdef CA_EXTRACT_PREDICT_EN
    for (genvar gi = 0; gi < Width; gi++) begin : g_pred
        assign predict[gi] = rule[nbhd(prev, gi)];
    end
    assign predict_valid = done && (state == READY);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= EMPTY;
            rule          <= '0;
            known         <= '0;
            conflict      <= 1'b0;
            conflict_cell <= '0;
            pairs         <= '0;
            prev          <= '0;
            cur           <= '0;
            idx           <= '0;
        end else if (ce) begin
            if (clear) begin
                state         <= EMPTY;
                rule          <= '0;
                known         <= '0;
                conflict      <= 1'b0;
                conflict_cell <= '0;
                pairs         <= '0;
                idx           <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (in_valid) begin
                            prev  <= in_state;
                            state <= READY;
                        end
                    end
                    READY: begin
                        if (in_valid) begin
                            cur   <= in_state;
                            idx   <= '0;
                            state <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (mismatch) begin
                            conflict      <= 1'b1;
                            conflict_cell <= idx;
                            state         <= HALT;
                        end else begin
                            rule[n]  <= b;
                            known[n] <= 1'b1;
                            if (last_cell) begin
                                prev  <= cur;
                                state <= READY;
                                if (pairs != 16'hFFFF) pairs <= pairs + 16'd1;
                            end else begin
                                idx <= idx + IW'(1);
                            end
                        end
                    end
                    default: state <= HALT;
                endcase
            end
        end
    end
endmodule
